// File: rtl/pe_pkg.sv
// Shared constants and state encoding for the priority encoder/decoder pair.
package pe_pkg;

    localparam int PE_WIDTH = 256;
    localparam int PE_IDX_W = 8;

    // Encoder-side view of the same vector: WIDTH request bits in, IDX_W-bit index out.
    localparam int PE_ENC_IN_W  = PE_WIDTH;
    localparam int PE_ENC_OUT_W = PE_IDX_W;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } pd_state_t;

endpackage

// File: rtl/decoder_256bit.sv
// Combinational IDX_W-to-WIDTH one-hot decoder used on the bit-set path.
module decoder_256bit
    import pe_pkg::*;
#(
    parameter int WIDTH = PE_WIDTH,
    parameter int IDX_W = PE_IDX_W
) (
    input  logic [IDX_W-1:0] i_idx,
    output logic [WIDTH-1:0] o_onehot
);

    always_comb begin
        o_onehot        = '0;
        o_onehot[i_idx] = 1'b1;
    end

endmodule

// File: rtl/priority_decoder_256bit.sv
// Rebuilds a WIDTH-bit vector from a stream of set-bit indices, counting distinct
// bits and flagging non-descending order; result is held until the consumer takes it.
module priority_decoder_256bit
    import pe_pkg::*;
#(
    parameter int WIDTH = PE_WIDTH,
    parameter int IDX_W = PE_IDX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] in_idx,
    input  logic             in_empty,
    input  logic             in_last,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_vec,
    output logic [IDX_W:0]   out_count,
    output logic             order_err,
    output logic             out_valid,
    input  logic             out_ready
);

    pd_state_t        r_state;
    pd_state_t        w_stateNext;

    logic [WIDTH-1:0] r_acc;
    logic [IDX_W:0]   r_cnt;
    logic             r_err;
    logic [IDX_W-1:0] r_prevIdx;
    logic             r_prevValid;

    logic [WIDTH-1:0] r_outVec;
    logic [IDX_W:0]   r_outCnt;
    logic             r_outErr;

    logic [WIDTH-1:0] w_onehot;
    logic [WIDTH-1:0] w_accNext;
    logic [IDX_W:0]   w_cntNext;
    logic             w_errNext;
    logic             w_accept;
    logic             w_handshake;
    logic             w_incr;
    logic             w_orderBad;

    decoder_256bit #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_decoder (
        .i_idx    (in_idx),
        .o_onehot (w_onehot)
    );

    assign w_accept    = (r_state == ST_ACCUM) && in_valid;
    assign w_handshake = (r_state == ST_HOLD) && out_ready;

    // A repeated index is also an order error, hence >= rather than >.
    assign w_incr     = !in_empty && !r_acc[in_idx];
    assign w_orderBad = !in_empty && r_prevValid && (in_idx >= r_prevIdx);

    assign w_accNext = in_empty ? r_acc : (r_acc | w_onehot);
    assign w_cntNext = r_cnt + (IDX_W+1)'(w_incr);
    assign w_errNext = r_err | w_orderBad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_ACCUM;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            ST_ACCUM: if (w_accept && in_last) w_stateNext = ST_HOLD;
            ST_HOLD:  if (out_ready)           w_stateNext = ST_ACCUM;
            default:                           w_stateNext = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_err       <= 1'b0;
            r_prevIdx   <= '0;
            r_prevValid <= 1'b0;
            r_outVec    <= '0;
            r_outCnt    <= '0;
            r_outErr    <= 1'b0;
        end else if (w_handshake) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_err       <= 1'b0;
            r_prevIdx   <= '0;
            r_prevValid <= 1'b0;
        end else if (w_accept) begin
            r_acc <= w_accNext;
            r_cnt <= w_cntNext;
            r_err <= w_errNext;
            if (!in_empty) begin
                r_prevIdx   <= in_idx;
                r_prevValid <= 1'b1;
            end
            if (in_last) begin
                r_outVec <= w_accNext;
                r_outCnt <= w_cntNext;
                r_outErr <= w_errNext;
            end
        end
    end

    assign in_ready  = (r_state == ST_ACCUM);
    assign out_valid = (r_state == ST_HOLD);
    assign out_vec   = r_outVec;
    assign out_count = r_outCnt;
    assign order_err = r_outErr;

endmodule

// File: tb/tb_priority_decoder_256bit.sv
// Self-checking bench for priority_decoder_256bit: directed table, corner sequences
// and random vectors compared against a set-based reference model.
module tb_priority_decoder_256bit;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [7:0]   in_idx;
    logic         in_empty;
    logic         in_last;
    logic         in_valid;
    logic         in_ready;
    logic [255:0] out_vec;
    logic [8:0]   out_count;
    logic         order_err;
    logic         out_valid;
    logic         out_ready;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int              nBeats;
        logic [3:0][7:0] idx;
        logic [3:0]      empty;
        logic [255:0]    expVec;
        int              expCnt;
        logic            expErr;
    } vec_rec_t;

    priority_decoder_256bit #(.WIDTH(256), .IDX_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_idx    (in_idx),
        .in_empty  (in_empty),
        .in_last   (in_last),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_vec   (out_vec),
        .out_count (out_count),
        .order_err (order_err),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One beat: drive at the falling edge, accepted at the next rising edge.
    task automatic applyStimulus(input logic [7:0] idx, input logic empty, input logic last);
        @(negedge clk);
        if (!in_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL beat_ready: in_ready got 0 expected 1");
        end
        in_idx   = idx;
        in_empty = empty;
        in_last  = last;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_empty = 1'b0;
    endtask

    // Called right after the last beat's edge: result must already be presented.
    task automatic checkOutput(input string name, input logic [255:0] eVec, input int eCnt,
                               input logic eErr, input int holdCycles);
        checkVal({name, "_valid"}, 256'(out_valid), 256'(1));
        checkVal({name, "_ready"}, 256'(in_ready), 256'(0));
        checkVal({name, "_vec"},   out_vec, eVec);
        checkVal({name, "_count"}, 256'(out_count), 256'(eCnt));
        checkVal({name, "_err"},   256'(order_err), 256'(eErr));
        for (int i = 0; i < holdCycles; i++) begin
            @(posedge clk);
            #1;
        end
        if (holdCycles > 0) begin
            checkVal({name, "_hold_vec"},   out_vec, eVec);
            checkVal({name, "_hold_valid"}, 256'(out_valid), 256'(1));
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkVal({name, "_drain"}, 256'(out_valid), 256'(0));
    endtask

    initial begin
        vec_rec_t     tbl[5];
        int           beatIdx[8];
        bit           beatEmpty[8];
        bit           hit[256];
        logic [255:0] mVec;
        int           mCnt;
        bit           mErr;
        int           prev;
        int           nb;
        int           cur;

        tbl[0] = '{1, {8'd0, 8'd0, 8'd0, 8'd2}, 4'b0000, 256'd4,   1, 1'b0};
        tbl[1] = '{2, {8'd0, 8'd0, 8'd0, 8'd3}, 4'b0000, 256'd9,   2, 1'b0};
        tbl[2] = '{1, {8'd0, 8'd0, 8'd0, 8'd0}, 4'b0001, 256'd0,   0, 1'b0};
        tbl[3] = '{3, {8'd0, 8'd3, 8'd3, 8'd0}, 4'b0000, 256'd9,   2, 1'b1};
        tbl[4] = '{3, {8'd0, 8'd4, 8'd0, 8'd9}, 4'b0010, 256'd528, 2, 1'b0};

        rst_n     = 1'b0;
        in_idx    = '0;
        in_empty  = 1'b0;
        in_last   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #12;
        checkVal("rst_ready", 256'(in_ready), 256'(1));
        checkVal("rst_valid", 256'(out_valid), 256'(0));
        checkVal("rst_vec",   out_vec, 256'd0);
        checkVal("rst_count", 256'(out_count), 256'(0));
        checkVal("rst_err",   256'(order_err), 256'(0));
        @(negedge clk);
        rst_n = 1'b1;

        for (int t = 0; t < 5; t++) begin
            for (int b = 0; b < tbl[t].nBeats; b++) begin
                applyStimulus(tbl[t].idx[b], tbl[t].empty[b], b == tbl[t].nBeats - 1);
            end
            checkOutput($sformatf("tbl%0d", t), tbl[t].expVec, tbl[t].expCnt, tbl[t].expErr, 0);
        end

        // Stall in HOLD with a beat waiting upstream; it must only be taken afterwards.
        applyStimulus(8'd5, 1'b0, 1'b1);
        @(negedge clk);
        in_idx   = 8'd1;
        in_empty = 1'b0;
        in_last  = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkVal("stall_vec",   out_vec, 256'd32);
            checkVal("stall_count", 256'(out_count), 256'(1));
            checkVal("stall_ready", 256'(in_ready), 256'(0));
            checkVal("stall_valid", 256'(out_valid), 256'(1));
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkVal("stall_release_ready", 256'(in_ready), 256'(1));
        checkVal("stall_release_valid", 256'(out_valid), 256'(0));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        checkOutput("stall_next", 256'd2, 1, 1'b0, 0);

        // Reset mid-vector discards the partial vector.
        applyStimulus(8'd7, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        checkVal("midrst_ready", 256'(in_ready), 256'(1));
        checkVal("midrst_valid", 256'(out_valid), 256'(0));
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(8'd1, 1'b0, 1'b1);
        checkOutput("midrst_next", 256'd2, 1, 1'b0, 0);

        // Reset while holding a result drops it.
        applyStimulus(8'd10, 1'b0, 1'b1);
        checkVal("holdrst_pre", 256'(out_valid), 256'(1));
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        checkVal("holdrst_valid", 256'(out_valid), 256'(0));
        checkVal("holdrst_vec",   out_vec, 256'd0);
        checkVal("holdrst_count", 256'(out_count), 256'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Every index from 255 down to 0.
        for (int i = 255; i >= 0; i--) begin
            applyStimulus(8'(i), 1'b0, i == 0);
        end
        checkOutput("full", {256{1'b1}}, 256, 1'b0, 1);

        // Random vectors against a set-based model.
        for (int v = 0; v < 40; v++) begin
            nb  = $urandom_range(1, 8);
            cur = $urandom_range(200, 255);
            for (int b = 0; b < nb; b++) begin
                beatEmpty[b] = ($urandom_range(0, 5) == 0);
                if (v % 2 == 0) begin
                    beatIdx[b] = $urandom_range(0, 255);
                end else begin
                    beatIdx[b] = cur;
                    cur = cur - $urandom_range(0, 30);
                    if (cur < 0) cur = 0;
                end
            end
            for (int k = 0; k < 256; k++) hit[k] = 1'b0;
            mErr = 1'b0;
            prev = 256;
            for (int b = 0; b < nb; b++) begin
                if (!beatEmpty[b]) begin
                    if (beatIdx[b] >= prev) mErr = 1'b1;
                    prev = beatIdx[b];
                    hit[beatIdx[b]] = 1'b1;
                end
            end
            mVec = '0;
            mCnt = 0;
            for (int k = 0; k < 256; k++) begin
                if (hit[k]) begin
                    mVec[k] = 1'b1;
                    mCnt++;
                end
            end
            for (int b = 0; b < nb; b++) begin
                applyStimulus(8'(beatIdx[b]), beatEmpty[b], b == nb - 1);
            end
            checkOutput($sformatf("rand%0d", v), mVec, mCnt, mErr, $urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/priority_decoder_256bit.md
PRIORITY_DECODER_256BIT -- requirements
Module: priority_decoder_256bit

Interface
REQ-001 SHALL have parameter WIDTH, default 256: reconstructed vector width.
REQ-002 SHALL have parameter IDX_W, default 8: index width, equal to log2(WIDTH).
REQ-003 SHALL have port clk  input  1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1: reset; one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port in_idx  input  IDX_W: bit index of one set bit, as produced by the priority encoder.
REQ-006 SHALL have port in_empty  input  1: beat carries no index (encoder valid=0); in_idx is ignored.
REQ-007 SHALL have port in_last  input  1: final beat of the current vector.
REQ-008 SHALL have port in_valid  input  1: input beat present.
REQ-009 SHALL have port in_ready  output  1: block accepts a beat.
REQ-010 SHALL have port out_vec  output  WIDTH: reconstructed vector.
REQ-011 SHALL have port out_count  output  IDX_W+1: number of distinct set bits in out_vec, 0..256.
REQ-012 SHALL have port order_err  output  1: accepted indices were not strictly descending, or an index was repeated.
REQ-013 SHALL have port out_valid  output  1: out_vec, out_count and order_err are valid.
REQ-014 SHALL have port out_ready  input  1: consumer accepts the output.

Function
REQ-015 SHALL implement two states: ACCUM (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-016 SHALL accept a beat in ACCUM when in_valid=1; in_ready=1 in ACCUM is unconditional.
REQ-017 SHALL, on an accepted non-empty beat, OR (1<<in_idx) into the accumulator.
REQ-018 SHALL increment the count only if the accumulator bit at in_idx was 0.
REQ-019 SHALL, on an accepted empty beat, leave the accumulator and count unchanged.
REQ-020 SHALL flag an order error when a non-empty beat has in_idx >= the previous non-empty index of the same vector; the flag is sticky until the vector is consumed.
REQ-021 SHALL, on an accepted beat with in_last=1, load out_vec, out_count and order_err from the accumulator, count and flag including that beat, and enter HOLD on the next edge (latency 1 cycle from the last beat to out_valid).
REQ-022 SHALL, in HOLD, hold all outputs stable until out_ready=1.
REQ-023 SHALL, on the HOLD handshake edge, clear the accumulator, count, flag and previous-index tracker, and return to ACCUM.
REQ-024 SHALL ignore in_valid while in HOLD; the upstream holds the beat because in_ready=0.
REQ-025 SHALL treat index 255 and index 0 as ordinary boundary values: a vector of 256 descending beats yields an all-ones out_vec and out_count=256 without wrap.
REQ-026 SHALL ignore out_ready while in ACCUM.

Reset
REQ-027 SHALL, on rst_n=0 and independent of clk, force state to ACCUM and out_vec=0, out_count=0, order_err=0, out_valid=0, and clear the accumulator and tracker.
REQ-028 SHALL discard, on reset mid-vector or in HOLD, any partial or pending vector with no output produced.
REQ-029 SHALL drive in_ready=1 during and after reset.

Structure
REQ-030 SHALL place WIDTH, IDX_W and the ACCUM/HOLD state encoding in shared package pe_pkg, alongside the encoder constants.
REQ-031 SHALL instantiate one combinational sub-module, decoder_256bit (IDX_W-to-WIDTH one-hot), for the bit-set path.
REQ-032 SHALL keep all sequential logic in priority_decoder_256bit.

Verification
REQ-033 SHALL cover: beat idx=2, last=1 -> next cycle out_vec=4, out_count=1, order_err=0, out_valid=1.
REQ-034 SHALL cover: beats idx=3 then idx=0, last on the second -> out_vec=9, out_count=2, order_err=0.
REQ-035 SHALL cover: single beat empty=1, last=1 -> out_vec=0, out_count=0, order_err=0.
REQ-036 SHALL cover: beats idx=0, idx=3, idx=3 (last) -> out_vec=9, out_count=2, order_err=1.
REQ-037 SHALL cover: out_ready=0 for 3 cycles in HOLD with in_valid=1 -> outputs stable, in_ready=0, no beat consumed; then out_ready=1 -> next beat accepted.
REQ-038 SHALL cover: rst_n pulsed low after beat idx=7 of an unfinished vector; then beat idx=1, last=1 -> out_vec=2, out_count=1.
